sram_phase_sequencer: RTL

SRAM_PHASE_SEQUENCER -- requirements
Module: sram_phase_sequencer

---
 rtl/sram_phase_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sram_phase_sequencer.sv
// Sequences up to NUM_STAGES SRAM clients in ascending index order, granting the
// shared SRAM port to one stage at a time, with an optional per-stage watchdog.
module sram_phase_sequencer #(
    parameter int          AW             = 18,
    parameter int          DW             = 16,
    parameter int          NUM_STAGES     = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_STAGES-1:0]    stage_mask,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic [2:0]               err_stage,
    output logic [2:0]               cur_stage,
    output logic [NUM_STAGES-1:0]    stage_start,
    input  logic [NUM_STAGES-1:0]    stage_done,
    input  logic [NUM_STAGES*AW-1:0] cl_raddr,
    input  logic [NUM_STAGES*AW-1:0] cl_waddr,
    input  logic [NUM_STAGES*DW-1:0] cl_wdata,
    input  logic [NUM_STAGES-1:0]    cl_wr_enable,
    output logic [DW-1:0]            cl_rdata,
    output logic [AW-1:0]            sram_raddr,
    output logic [AW-1:0]            sram_waddr,
    output logic [DW-1:0]            sram_wdata,
    output logic                     sram_wr_enable,
    input  logic [DW-1:0]            sram_rdata
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [NUM_STAGES-1:0]   mask_q, mask_d;
    logic [2:0]              k_q, k_d;
    logic                    hold_q, hold_d;
    logic [31:0]             wd_cnt_q, wd_cnt_d;
    logic                    timeout_q, timeout_d;
    logic [2:0]              err_stage_q, err_d;
    logic                    busy_q, done_q;
    logic [2:0]              cur_stage_q;
    logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
    logic                    grant, grant_d;
    logic                    done_k;
    logic [3:0]              first, nxt;

    // Returns {found, index} of the lowest set bit at or above index lo.
    function automatic logic [3:0] find_set(input logic [NUM_STAGES-1:0] mask, input int lo);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (mask[i] && i >= lo) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign grant = (state_q == LAUNCH) || (state_q == RUN);

    always_comb begin
        done_k = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (k_q == 3'(i)) done_k = stage_done[i];
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        k_d       = k_q;
        hold_d    = 1'b0;
        timeout_d = timeout_q;
        err_d     = err_stage_q;
        first     = find_set(stage_mask, 0);
        nxt       = find_set(mask_q, int'(k_q) + 1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    timeout_d = 1'b0;
                    err_d     = 3'd0;
                    mask_d    = stage_mask;
                    if (first[3]) begin
                        k_d     = first[2:0];
                        state_d = LAUNCH;
                    end else begin
                        // Empty mask: spend one busy cycle before the done pulse.
                        state_d = FINISH;
                        hold_d  = 1'b1;
                    end
                end
            end
            LAUNCH: state_d = RUN;
            RUN: begin
                if (done_k) begin
                    if (nxt[3]) begin
                        k_d     = nxt[2:0];
                        state_d = LAUNCH;
                    end else begin
                        state_d = FINISH;
                    end
                end else if (TIMEOUT_CYCLES != 32'd0 && wd_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    timeout_d = 1'b1;
                    err_d     = k_q;
                    state_d   = FINISH;
                end
            end
            FINISH: state_d = hold_q ? FINISH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d       = (state_d == LAUNCH) || (state_d == RUN);
        wd_cnt_d      = (state_q == RUN) ? wd_cnt_q + 32'd1 : 32'd0;
        stage_start_d = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_start_d[i] = (state_d == LAUNCH) && (k_d == 3'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            k_q           <= 3'd0;
            hold_q        <= 1'b0;
            wd_cnt_q      <= 32'd0;
            timeout_q     <= 1'b0;
            err_stage_q   <= 3'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cur_stage_q   <= 3'd0;
            stage_start_q <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            k_q           <= k_d;
            hold_q        <= hold_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_q     <= timeout_d;
            err_stage_q   <= err_d;
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == FINISH) && !hold_d;
            cur_stage_q   <= grant_d ? k_d : 3'd0;
            stage_start_q <= stage_start_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign err_stage   = err_stage_q;
    assign cur_stage   = cur_stage_q;
    assign stage_start = stage_start_q;

    // Forced to zero outside the grant (and during reset) so no write can leak.
    always_comb begin
        sram_raddr     = '0;
        sram_waddr     = '0;
        sram_wdata     = '0;
        sram_wr_enable = 1'b0;
        if (grant && !reset) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (k_q == 3'(i)) begin
                    sram_raddr     = cl_raddr[i*AW +: AW];
                    sram_waddr     = cl_waddr[i*AW +: AW];
                    sram_wdata     = cl_wdata[i*DW +: DW];
                    sram_wr_enable = cl_wr_enable[i];
                end
            end
        end
    end

    assign cl_rdata = sram_rdata;

endmodule
